inst_prefetch: RTL and testbench

//   Instruction fetch stage that sits directly upstream of the control unit.

---
 rtl/inst_prefetch.sv | 147 ++++++++++++++
 tb/tb_inst_prefetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction fetch stage feeding the control unit.
// Issues word reads at a 7-bit fetch PC over the shared memory port (1-cycle
// read latency), buffers returned words with their PCs in a small FIFO and
// presents the head downstream over valid/ready. A redirect flushes buffered
// and in-flight fetches and restarts at the new PC.
// Optional feature: define INST_BYPASS_EN to forward a response straight to
// the outputs when the FIFO is empty (redirect-to-valid latency 2 instead of 3).
module inst_prefetch #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_gnt,
  output logic              mem_re,
  output logic [PC_W:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Fetch-side state
  logic            r_run;       // low during and the cycle after reset, keeps mem_re quiet
  logic [PC_W-1:0] r_fpc;
  logic [PC_W-1:0] r_tag_pc;    // PC of the request whose data returns this cycle
  logic            r_inflight;

  // FIFO state
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [DATA_W-1:0] w_ent_data [DEPTH];
  logic [PC_W-1:0]   w_ent_pc   [DEPTH];

  logic [CW:0] w_used;
  logic        w_accept;
  logic        w_empty;
  logic        w_resp;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;

  // Credit: buffered words plus the outstanding one must leave room for a new one,
  // so a response can always be stored without checking for full.
  assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign mem_re   = r_run & ~redirect & (w_used < (CW+1)'(DEPTH));
  assign mem_addr = {r_fpc, 1'b0};
  assign w_accept = mem_re & mem_gnt;
  assign w_empty  = (r_count == '0);
  // A response coinciding with a redirect belongs to the old stream: drop it.
  assign w_resp   = r_inflight & ~redirect;
`ifdef INST_BYPASS_EN
  assign w_bypass = w_empty & w_resp;
`else
  assign w_bypass = 1'b0;
`endif
  // A bypassed word that is consumed immediately never enters the FIFO.
  assign w_push = w_resp & ~(w_bypass & inst_ready);
  assign w_pop  = ~w_empty & inst_ready & ~redirect;

  // Fetch PC, request tag and in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fpc      <= '0;
      r_tag_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_accept;
      if (w_accept) begin
        r_tag_pc <= r_fpc;
      end
      if (redirect) begin
        r_fpc <= redirect_pc;
      end else if (w_accept) begin
        r_fpc <= r_fpc + PC_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage, one slot per generate iteration
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] r_data;
      logic [PC_W-1:0]   r_pc;
      // Capture the returning word when the write pointer selects this slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
          r_pc   <= '0;
        end else if (w_push && (r_wptr == AW'(gi))) begin
          r_data <= mem_rdata;
          r_pc   <= r_tag_pc;
        end
      end
      assign w_ent_data[gi] = r_data;
      assign w_ent_pc[gi]   = r_pc;
    end
  endgenerate

  // Head presentation: FIFO head when non-empty, else optional bypass, else zeros
  always_comb begin
    inst       = '0;
    inst_pc    = '0;
    inst_valid = 1'b0;
    if (!w_empty) begin
      inst       = w_ent_data[r_rptr];
      inst_pc    = w_ent_pc[r_rptr];
      inst_valid = 1'b1;
    end else if (w_bypass) begin
      inst       = mem_rdata;
      inst_pc    = r_tag_pc;
      inst_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed testbench for inst_prefetch. The memory model returns 0x5A in the
// high byte and the byte address in the low byte, so every popped word can be
// checked against its PC.
module tb_inst_prefetch;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 7;
  localparam int DATA_W = 16;
`ifdef INST_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_gnt = 1'b0;
  logic              mem_re;
  logic [PC_W:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata = 16'hDEAD;
  logic              redirect = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic [DATA_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic       acc_q  = 1'b0;
  logic [7:0] addr_q = 8'h00;
  logic [PC_W-1:0] q_pc[$];
  int              q_cyc[$];

  always #5 clk = ~clk;

  inst_prefetch #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_gnt(mem_gnt), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= acc_q ? {8'h5A, addr_q} : 16'hDEAD;
  end

  // Sample away from the active edge: memory requests and downstream pops
  always @(negedge clk) begin
    acc_q  = rst_n & mem_re & mem_gnt;
    addr_q = mem_addr;
    if (rst_n && inst_valid && inst_ready) begin
      q_pc.push_back(inst_pc);
      q_cyc.push_back(cyc);
      chk("pop_data", 32'(inst), 32'({8'h5A, inst_pc, 1'b0}));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nacc;
    int lat;
    logic found;
    logic [PC_W-1:0] exp_pc;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", 32'(inst), 0);
    chk("rst_inst_pc", 32'(inst_pc), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);

    // 1: streaming with grant and ready always high
    tick();
    rst_n = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
    q_pc.delete(); q_cyc.delete();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_re) begin found = 1'b1; break; end
    end
    chk("t1_req_seen", 32'(found), 1);
    chk("t1_addr0", 32'(mem_addr), 32'h00);
    @(negedge clk); chk("t1_addr1", 32'(mem_addr), 32'h02);
    @(negedge clk); chk("t1_addr2", 32'(mem_addr), 32'h04);
    repeat (10) @(negedge clk);
    chk("t1_npop", 32'(q_pc.size() >= 8), 1);
    if (q_pc.size() >= 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("t1_pc%0d", k), 32'(q_pc[k]), k);
      chk("t1_back_to_back", q_cyc[7] - q_cyc[0], 7);
    end

    // 2: consumer stalled, credit limits requests to DEPTH
    tick();
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 7'h00;
    tick();
    redirect = 1'b0;
    q_pc.delete(); q_cyc.delete();
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_re && mem_gnt) nacc++;
    end
    chk("t2_accepts", nacc, DEPTH);
    chk("t2_re_low", 32'(mem_re), 0);
    chk("t2_valid", 32'(inst_valid), 1);
    chk("t2_head_pc", 32'(inst_pc), 0);
    chk("t2_head_inst", 32'(inst), 32'h5A00);
    repeat (2) @(negedge clk);
    chk("t2_hold_pc", 32'(inst_pc), 0);
    tick();
    inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t2_npop", 32'(q_pc.size() >= 5), 1);
    if (q_pc.size() >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("t2_pc%0d", k), 32'(q_pc[k]), k);

    // 3: grant toggling; fetch PC advances only on granted cycles
    tick();
    redirect = 1'b1; redirect_pc = 7'h20;
    tick();
    redirect = 1'b0;
    q_pc.delete(); q_cyc.delete();
    exp_pc = 7'h20;
    for (int i = 0; i < 16; i++) begin
      mem_gnt = i[0];
      @(negedge clk);
      if (mem_re && mem_gnt) begin
        chk($sformatf("t3_addr_%0d", i), 32'(mem_addr), 32'({exp_pc, 1'b0}));
        exp_pc = exp_pc + 7'd1;
      end
      tick();
    end
    mem_gnt = 1'b1;
    repeat (8) @(negedge clk);
    chk("t3_npop", 32'(q_pc.size() >= 10), 1);
    if (q_pc.size() >= 10)
      for (int k = 0; k < 10; k++) chk($sformatf("t3_pc%0d", k), 32'(q_pc[k]), 32'h20 + k);

    // 4: redirect with a request in flight
    tick();
    redirect = 1'b1; redirect_pc = 7'h40;
    @(negedge clk);
    chk("t4_no_req", 32'(mem_re), 0);
    tick();
    redirect = 1'b0;
    q_pc.delete(); q_cyc.delete();
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (inst_valid) begin lat = k; break; end
    end
    chk("t4_latency", lat, EXP_LAT);
    repeat (6) @(negedge clk);
    chk("t4_npop", 32'(q_pc.size() >= 2), 1);
    if (q_pc.size() >= 2) begin
      chk("t4_pc0", 32'(q_pc[0]), 32'h40);
      chk("t4_pc1", 32'(q_pc[1]), 32'h41);
    end

    // 5: fetch PC wrap 0x7F -> 0x00
    tick();
    redirect = 1'b1; redirect_pc = 7'h7E;
    tick();
    redirect = 1'b0;
    q_pc.delete(); q_cyc.delete();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_re && mem_addr == 8'hFE) begin found = 1'b1; break; end
    end
    chk("t5_addr_fe", 32'(found), 1);
    @(negedge clk);
    chk("t5_addr_wrap", 32'(mem_addr), 32'h00);
    repeat (6) @(negedge clk);
    chk("t5_npop", 32'(q_pc.size() >= 4), 1);
    if (q_pc.size() >= 4) begin
      chk("t5_pc0", 32'(q_pc[0]), 32'h7E);
      chk("t5_pc1", 32'(q_pc[1]), 32'h7F);
      chk("t5_pc2", 32'(q_pc[2]), 32'h00);
      chk("t5_pc3", 32'(q_pc[3]), 32'h01);
    end

    // 6: asynchronous reset with the FIFO three-quarters full
    tick();
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 7'h30;
    tick();
    redirect = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_re && mem_gnt) nacc++;
      tick();
      if (nacc == 3) begin mem_gnt = 1'b0; break; end
    end
    chk("t6_fill_accepts", nacc, 3);
    tick(); tick();
    chk("t6_pre_valid", 32'(inst_valid), 1);
    chk("t6_pre_pc", 32'(inst_pc), 32'h30);
    chk("t6_pre_re", 32'(mem_re), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(inst_valid), 0);
    chk("t6_rst_re", 32'(mem_re), 0);
    chk("t6_rst_inst", 32'(inst), 0);
    chk("t6_rst_pc", 32'(inst_pc), 0);
    tick(); tick();
    q_pc.delete(); q_cyc.delete();
    rst_n = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_npop", 32'(q_pc.size() >= 2), 1);
    if (q_pc.size() >= 2) begin
      chk("t6_first_pc", 32'(q_pc[0]), 0);
      chk("t6_second_pc", 32'(q_pc[1]), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
